// File: rtl/soc_clock_divider_bank.sv
// soc_clock_divider_bank: N-channel tick / 50% divided-clock generator with staggered resets.
// Runtime divider writes are built only when SOC_CLKDIV_RUNTIME_CFG_EN is defined.
module soc_clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 7,
  parameter int RST_HOLD    = 16,
  parameter int RST_STAGGER = 4,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic [NUM_CH-1:0]    cfg_pending,
  output logic                 cfg_err,
  input  logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    div_out,
  output logic [NUM_CH-1:0]    ch_rst
);

  localparam int RMAX = RST_HOLD + (NUM_CH - 1) * RST_STAGGER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  logic [RW-1:0]        rc_q, rc_d;
  logic [NUM_CH-1:0]    rst_q, rst_d;
  logic [NUM_CH-1:0]    tick_q, tick_d;
  logic [NUM_CH-1:0]    dout_q, dout_d;
  logic [NUM_CH-1:0]    act, wrap;
  logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
  logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
  logic [DIV_WIDTH-1:0] dv    [NUM_CH];

  assign rc_d = (rc_q == RW'(RMAX)) ? rc_q : rc_q + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rst_d[i]  = rst_q[i] & (rc_d < RW'(RST_HOLD + i * RST_STAGGER));
      act[i]    = ~rst_q[i] & ch_en[i];
      wrap[i]   = cnt_q[i] == dv[i] - 1'b1;
      cnt_d[i]  = '0;
      tick_d[i] = 1'b0;
      dout_d[i] = 1'b0;
      if (act[i]) begin
        tick_d[i] = wrap[i];
        dout_d[i] = dout_q[i] ^ wrap[i];
        if (!wrap[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rc_q   <= '0;
      rst_q  <= '1;
      tick_q <= '0;
      dout_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      rc_q   <= rc_d;
      rst_q  <= rst_d;
      tick_q <= tick_d;
      dout_q <= dout_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign tick    = tick_q;
  assign div_out = dout_q;
  assign ch_rst  = rst_q;

`ifdef SOC_CLKDIV_RUNTIME_CFG_EN
  localparam logic [CW:0] NCH = (CW + 1)'(NUM_CH);

  logic [DIV_WIDTH-1:0] dv_q [NUM_CH];
  logic [DIV_WIDTH-1:0] dv_d [NUM_CH];
  logic [DIV_WIDTH-1:0] pv_q [NUM_CH];
  logic [DIV_WIDTH-1:0] pv_d [NUM_CH];
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic                 err_q, err_d, bad;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) dv[i] = dv_q[i];
  end

  // New divider only lands on a wrap edge (or idle), so no runt half-periods.
  always_comb begin
    bad   = cfg_we & (({1'b0, cfg_ch} >= NCH) | (cfg_div == '0));
    err_d = err_q | bad;
    for (int i = 0; i < NUM_CH; i++) begin
      dv_d[i]   = dv_q[i];
      pv_d[i]   = pv_q[i];
      pend_d[i] = pend_q[i];
      if (pend_q[i] & (~act[i] | wrap[i])) begin
        dv_d[i]   = pv_q[i];
        pend_d[i] = 1'b0;
      end
      if (cfg_we & ~bad & (cfg_ch == CW'(i))) begin
        pv_d[i]   = cfg_div;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        dv_q[i] <= DEF;
        pv_q[i] <= DEF;
      end
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        dv_q[i] <= dv_d[i];
        pv_q[i] <= pv_d[i];
      end
    end
  end

  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_ch, cfg_div};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) dv[i] = DEF;
  end

  assign cfg_pending = '0;
  assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_soc_clock_divider_bank.sv
// tb_soc_clock_divider_bank: directed stimulus, tick scoreboard checked by a monitor.
// Expectations follow SOC_CLKDIV_RUNTIME_CFG_EN when it is defined for the build.
module tb_soc_clock_divider_bank;
  localparam int N = 5;

`ifdef SOC_CLKDIV_RUNTIME_CFG_EN
  localparam bit CFG_ON = 1'b1;
`else
  localparam bit CFG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         in_rst;
  logic         cfg_we;
  logic [2:0]   cfg_ch;
  logic [15:0]  cfg_div;
  logic [N-1:0] cfg_pending;
  logic         cfg_err;
  logic [N-1:0] ch_en;
  logic [N-1:0] tick;
  logic [N-1:0] div_out;
  logic [N-1:0] ch_rst;

  always #5 clk = ~clk;

  soc_clock_divider_bank #(
    .NUM_CH(N), .DIV_WIDTH(16), .DEFAULT_DIV(7),
    .RST_HOLD(16), .RST_STAGGER(4)
  ) dut (
    .in_clk(clk), .in_rst(in_rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .ch_en(ch_en), .tick(tick), .div_out(div_out), .ch_rst(ch_rst)
  );

  typedef struct {
    int   k;
    int   ch;
    logic d;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  drop = 0;
  int  errors = 0;
  int  checks = 0;
  bit  live = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int kk();
    return cyc - drop;
  endfunction

  function automatic void push(input int k, input int ch, input logic d);
    ev_t e;
    e.k  = k;
    e.ch = ch;
    e.d  = d;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (k=%0d)", nm, got, want, kk());
    end
  endtask

  task automatic at(input int n);
    while (cyc - drop < n) @(negedge clk);
  endtask

  // Scoreboard monitor: every tick must match the head entry.
  always @(negedge clk) begin
    if (live) begin
      while (exp_q.size() != 0 && exp_q[0].k < kk()) begin
        checks++;
        errors++;
        $display("FAIL tick_missing: ch%0d no tick at k=%0d, required tick with div_out=%b",
                 exp_q[0].ch, exp_q[0].k, exp_q[0].d);
        void'(exp_q.pop_front());
      end
      for (int c = 0; c < N; c++) begin
        if (tick[c]) begin
          int   fk;
          int   fc;
          logic fd;
          fk = -1;
          fc = -1;
          fd = 1'bx;
          if (exp_q.size() != 0) begin
            fk = exp_q[0].k;
            fc = exp_q[0].ch;
            fd = exp_q[0].d;
          end
          checks++;
          if (fk != kk() || fc != c || fd !== div_out[c]) begin
            errors++;
            $display("FAIL tick_ch%0d: tick div_out=%b at k=%0d, required k=%0d ch=%0d div_out=%b",
                     c, div_out[c], kk(), fk, fc, fd);
          end
          if (fk == kk()) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: k=%0d, required finish by k=140", kk());
    $fatal(1);
  end

  initial begin
    logic [N-1:0] e;
    in_rst  = 1'b1;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    ch_en   = 5'b00001;
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_dout", div_out, 0);
    chk("rst_chrst", ch_rst, 5'h1f);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_err", cfg_err, 0);

    in_rst = 1'b0;
    drop   = cyc;
    live   = 1'b1;
    push(23, 0, 1'b1);
    push(30, 0, 1'b0);
    push(37, 0, 1'b1);
    push(44, 0, 1'b0);

    for (int k = 1; k <= 34; k++) begin
      at(k);
      for (int c = 0; c < N; c++) e[c] = (k < 16 + 4 * c);
      chk($sformatf("release_k%0d", k), ch_rst, e);
    end

    at(46);
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 16'd3;
    if (CFG_ON) begin
      push(51, 0, 1'b1);
      push(54, 0, 1'b0);
      push(57, 0, 1'b1);
      push(60, 0, 1'b0);
      push(63, 0, 1'b1);
      push(66, 0, 1'b0);
    end else begin
      push(51, 0, 1'b1);
      push(58, 0, 1'b0);
      push(65, 0, 1'b1);
    end
    at(47);
    cfg_we = 1'b0;
    chk("pend_set", cfg_pending, CFG_ON ? 1 : 0);
    at(50);
    chk("pend_hold", cfg_pending, CFG_ON ? 1 : 0);
    at(51);
    chk("pend_clr_at_tick", cfg_pending, 0);

    at(66);
    ch_en[0] = 1'b0;
    at(67);
    chk("dis0_dout", div_out[0], 0);
    chk("dis0_tick", tick[0], 0);

    at(68);
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 16'd2;
    at(69);
    cfg_we = 1'b0;
    chk("pend_idle_set", cfg_pending, CFG_ON ? 1 : 0);
    at(70);
    chk("pend_idle_clr", cfg_pending, 0);
    if (CFG_ON) begin
      at(72);
      ch_en[0] = 1'b1;
      push(74, 0, 1'b1);
      push(76, 0, 1'b0);
      at(76);
      ch_en[0] = 1'b0;
    end

    at(79);
    chk("err_pre", cfg_err, 0);
    cfg_we  = 1'b1;
    cfg_ch  = 3'd5;
    cfg_div = 16'd3;
    at(80);
    chk("err_range", cfg_err, CFG_ON ? 1 : 0);
    chk("pend_range", cfg_pending, 0);
    cfg_ch  = 3'd1;
    cfg_div = 16'd0;
    at(81);
    cfg_we = 1'b0;
    chk("pend_zero", cfg_pending, 0);
    at(82);
    chk("err_sticky", cfg_err, CFG_ON ? 1 : 0);

    at(84);
    ch_en[1] = 1'b1;
    push(91, 1, 1'b1);
    push(98, 1, 1'b0);
    push(105, 1, 1'b1);
    at(107);
    chk("dout1_high", div_out[1], 1);
    ch_en[1] = 1'b0;
    at(108);
    chk("dis1_dout", div_out[1], 0);
    chk("dis1_tick", tick[1], 0);
    at(110);
    ch_en[1] = 1'b1;
    push(117, 1, 1'b1);
    at(118);
    ch_en[1] = 1'b0;

    if (CFG_ON) begin
      at(120);
      cfg_we  = 1'b1;
      cfg_ch  = 3'd2;
      cfg_div = 16'd1;
      at(121);
      cfg_we = 1'b0;
      chk("pend_d1_set", cfg_pending, 5'b00100);
      at(122);
      chk("pend_d1_clr", cfg_pending, 0);
      ch_en[2] = 1'b1;
      push(123, 2, 1'b1);
      push(124, 2, 1'b0);
      push(125, 2, 1'b1);
      push(126, 2, 1'b0);
      at(126);
      ch_en[2] = 1'b0;
      at(127);
      chk("dis2_tick", tick[2], 0);
    end

    at(130);
    in_rst = 1'b1;
    at(131);
    chk("midrst_chrst", ch_rst, 5'h1f);
    chk("midrst_tick", tick, 0);
    chk("midrst_dout", div_out, 0);
    chk("midrst_err", cfg_err, 0);
    chk("midrst_pend", cfg_pending, 0);
    in_rst = 1'b0;

    at(135);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/soc_clock_divider_bank.md
# soc_clock_divider_bank

Multi-channel clock-enable and divided-clock generator with staggered reset release, running entirely in the `main_clk` domain. It generalises the single fixed UART post-divider into `NUM_CH` independent channels, each with a runtime-programmable divider, per-channel enable and its own sequenced active-high reset. It sits directly behind the SoC clock/reset generator and feeds UART, timer and peripheral baud/tick inputs.

## Interface
- `NUM_CH`, 4: number of channels (1–16).
- `DIV_WIDTH`, 16: divider register width (2–32).
- `DEFAULT_DIV`, 7: half-period divider loaded into every channel on reset. Must satisfy 1 ≤ `DEFAULT_DIV` < 2^`DIV_WIDTH`.
- `RST_HOLD`, 16: cycles `ch_rst[0]` stays asserted after `in_rst` drops (≥1).
- `RST_STAGGER`, 4: additional cycles between successive channel reset releases (≥0).

Ports (`CW` = max(1, $clog2(`NUM_CH`))):
- `in_clk` in 1: single clock, normally `main_clk`.
- `in_rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: one-cycle divider write strobe.
- `cfg_ch` in `CW`: target channel.
- `cfg_div` in `DIV_WIDTH`: new half-period divider D.
- `cfg_pending` out `NUM_CH`: write accepted but not yet applied.
- `cfg_err` out 1: sticky error flag; cleared only by `in_rst`.
- `ch_en` in `NUM_CH`: per-channel run enable.
- `tick` out `NUM_CH`: one-cycle pulse every D cycles.
- `div_out` out `NUM_CH`: square wave with period 2·D cycles and 50% duty.
- `ch_rst` out `NUM_CH`: per-channel active-high reset.

## Operation
- Reset values while `in_rst`=1:
  - `tick`=0, `div_out`=0, `ch_rst`=all 1, `cfg_pending`=0, `cfg_err`=0.
  - Every divider = `DEFAULT_DIV`; every counter = 0.
- Reset sequencer:
  - Free-running release counter, saturating at `RST_HOLD`+(`NUM_CH`−1)·`RST_STAGGER`.
  - `ch_rst[i]` deasserts at the edge where the count reaches `RST_HOLD`+i·`RST_STAGGER`.
  - Once released, a channel stays released until `in_rst`.
- A channel is active when `ch_rst[i]`=0 and `ch_en[i]`=1.
- Active channel:
  - Counter `cnt` counts 0..D−1.
  - At the edge where `cnt`==D−1: `cnt`←0, `tick[i]`←1, `div_out[i]`←~`div_out[i]`.
  - At every other edge: `cnt`←`cnt`+1, `tick[i]`←0.
- Inactive channel: `cnt`←0, `tick[i]`←0, `div_out[i]`←0. This gives a clean restart on re-enable.
- Divider write, when `cfg_we`=1:
  - `cfg_ch` ≥ `NUM_CH` or `cfg_div`==0: write ignored, `cfg_err`←1.
  - Otherwise the value is stored as the channel's pending value and `cfg_pending[ch]`←1.
  - A second write while pending overwrites the pending value (last write wins).
- Applying a pending value (glitch-free):
  - Active channel: applied at its next wrap edge, the same edge `tick` rises. The new D governs the following interval.
  - Inactive channel: applied at the next edge.
  - `cfg_pending` clears on the apply edge.
  - If a write to the same channel coincides with the apply edge, the new write becomes pending again.
- `in_rst` mid-operation: all state returns to reset values on the next edge and pending writes are discarded.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- First `tick[i]` is high exactly D cycles after the first active cycle.
- D=1: `tick` stays high continuously and `div_out` toggles every cycle.
- `cfg_err` and `cfg_pending` update one edge after the `cfg_we` cycle.
- Disable takes effect on the next edge; `tick` never extends beyond one cycle.

## Configuration
- `SOC_CLKDIV_RUNTIME_CFG_EN` defined: divider write path active, as described above.
- Undefined:
  - `cfg_we`, `cfg_ch` and `cfg_div` are ignored.
  - Dividers are the constant `DEFAULT_DIV`.
  - `cfg_pending` and `cfg_err` are tied to 0.
  - No pending-value registers are synthesised.

## Test plan
- Reset release: `NUM_CH`=4, `RST_HOLD`=16, `RST_STAGGER`=4; drop `in_rst` at cycle 0 -> `ch_rst` bits deassert at cycles 16, 20, 24 and 28 respectively.
- Default divide: channel 0 with D=7 and `ch_en`=1 -> `tick` at 7, 14, 21… cycles after release; `div_out` period 14 with 7 high / 7 low.
- Glitch-free update: with D=7, write D=3 mid-interval -> the current 7-cycle interval completes, `cfg_pending[0]` clears at that tick, then ticks follow every 3 cycles.
- Error path: write `cfg_ch`=5 (`NUM_CH`=4), then `cfg_div`=0 -> `cfg_err`=1 and all dividers unchanged; `cfg_err` holds until `in_rst`.
- Enable toggling: drop `ch_en[1]` while `div_out[1]`=1 -> next cycle `div_out[1]`=0 and `tick[1]`=0; re-enable -> first tick D cycles later.
- Macro off: rebuild without `SOC_CLKDIV_RUNTIME_CFG_EN` and write D=3 -> period stays 2·`DEFAULT_DIV` and `cfg_pending`=0.
